// File: rtl/muldiv_ctrl_pkg.sv
// Shared types for the multiply/divide sequencer: op encoding, FSM states and op-class helpers.
package muldiv_ctrl_pkg;

  localparam int unsigned MulLatencyDefault = 2;

  typedef enum logic [3:0] {
    OpNone  = 4'd0,
    OpMult  = 4'd1,
    OpMultu = 4'd2,
    OpDiv   = 4'd3,
    OpDivu  = 4'd4,
    OpMadd  = 4'd5,
    OpMaddu = 4'd6,
    OpMsub  = 4'd7,
    OpMsubu = 4'd8
  } muldiv_op_t;

  typedef enum logic [1:0] {
    StIdle,
    StMul,
    StDiv,
    StDone
  } muldiv_state_t;

  function automatic logic is_mul_op(input muldiv_op_t op);
    return (op == OpMult) || (op == OpMultu) || (op == OpMadd) || (op == OpMaddu) ||
           (op == OpMsub) || (op == OpMsubu);
  endfunction

  function automatic logic is_div_op(input muldiv_op_t op);
    return (op == OpDiv) || (op == OpDivu);
  endfunction

  function automatic logic is_signed_op(input muldiv_op_t op);
    return (op == OpMult) || (op == OpMadd) || (op == OpMsub) || (op == OpDiv);
  endfunction

endpackage

// File: rtl/divu_iter.sv
// Unsigned radix-2 restoring divider; a load also performs the first iteration,
// each step performs one more.
module divu_iter (
  input  logic        clk,
  input  logic        resetn,
  input  logic        load,
  input  logic        step,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  logic [31:0] r_quo, r_rem, r_dsr;
  logic [31:0] w_quo_in, w_rem_in, w_dsr_in;
  logic [32:0] w_shift, w_diff;

  always_comb begin
    w_rem_in = load ? 32'd0 : r_rem;
    w_quo_in = load ? dividend : r_quo;
    w_dsr_in = load ? divisor : r_dsr;
    w_shift  = {w_rem_in, w_quo_in[31]};
    // Bit 32 of the difference is the borrow: set when the trial subtract must be undone.
    w_diff   = w_shift - {1'b0, w_dsr_in};
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_quo <= '0;
      r_rem <= '0;
      r_dsr <= '0;
    end else if (load || step) begin
      r_dsr <= w_dsr_in;
      if (!w_diff[32]) begin
        r_rem <= w_diff[31:0];
        r_quo <= {w_quo_in[30:0], 1'b1};
      end else begin
        r_rem <= w_shift[31:0];
        r_quo <= {w_quo_in[30:0], 1'b0};
      end
    end
  end

  assign quotient  = r_quo;
  assign remainder = r_rem;

endmodule

// File: rtl/muldiv_ctrl.sv
// Multi-cycle HI/LO multiply/divide sequencer for EXE: stalls the pipe while busy,
// presents {HI,LO} with a valid that holds across external stalls.
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
#(
  parameter int unsigned MUL_LATENCY = MulLatencyDefault,
  parameter int unsigned DIV_ITER    = 32
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        EXE_Valid,
  input  logic [3:0]  EXE_MulDivOp,
  input  logic [31:0] EXE_SrcA,
  input  logic [31:0] EXE_SrcB,
  input  logic [31:0] HI_In,
  input  logic [31:0] LO_In,
  input  logic        EXE_Stall,
  input  logic        Flush_Exception,
  output logic        DIVMULTBusy,
  output logic        MulDiv_ResValid,
  output logic [31:0] MulDiv_HI,
  output logic [31:0] MulDiv_LO
);

  localparam int unsigned CntW = $clog2(DIV_ITER + 1);
  localparam logic [CntW-1:0] MulCntInit = CntW'(MUL_LATENCY - 1);
  localparam logic [CntW-1:0] DivCntInit = CntW'(DIV_ITER);
  localparam logic [CntW-1:0] CntOne = CntW'(1);

  muldiv_state_t r_state, w_state_nxt;
  logic [CntW-1:0] r_cnt, w_cnt_nxt;
  logic [31:0] r_hi, r_lo;
  logic        r_neg_q, r_neg_r;
  muldiv_op_t  w_op;
  logic        w_start, w_sgn, w_res_load, w_div_load, w_div_step;
  logic [63:0] w_ax, w_bx, w_prod, w_acc, w_mul_res, w_mul_out, w_res_nxt;
  logic [31:0] w_abs_a, w_abs_b, w_quo, w_rem, w_quo_fix, w_rem_fix;

  assign w_op    = muldiv_op_t'(EXE_MulDivOp);
  assign w_start = (r_state == StIdle) && EXE_Valid && (is_mul_op(w_op) || is_div_op(w_op)) &&
                   !Flush_Exception;
  assign w_sgn   = is_signed_op(w_op);

  // Full 64-bit accumulate result is formed in the start cycle, then carried through the pipe.
  always_comb begin
    w_ax   = {{32{w_sgn & EXE_SrcA[31]}}, EXE_SrcA};
    w_bx   = {{32{w_sgn & EXE_SrcB[31]}}, EXE_SrcB};
    w_prod = w_ax * w_bx;
    w_acc  = {HI_In, LO_In};
    case (w_op)
      OpMadd, OpMaddu: w_mul_res = w_acc + w_prod;
      OpMsub, OpMsubu: w_mul_res = w_acc - w_prod;
      default:         w_mul_res = w_prod;
    endcase
  end

  if (MUL_LATENCY > 1) begin : g_mul_pipe
    logic [63:0] r_pipe [MUL_LATENCY-1];
    always_ff @(posedge clk) begin
      if (!resetn) begin
        for (int unsigned i = 0; i < MUL_LATENCY - 1; i++) r_pipe[i] <= '0;
      end else begin
        r_pipe[0] <= w_mul_res;
        for (int unsigned i = 1; i < MUL_LATENCY - 1; i++) r_pipe[i] <= r_pipe[i-1];
      end
    end
    assign w_mul_out = r_pipe[MUL_LATENCY-2];
  end else begin : g_mul_comb
    assign w_mul_out = w_mul_res;
  end

  assign w_abs_a   = (w_sgn && EXE_SrcA[31]) ? -EXE_SrcA : EXE_SrcA;
  assign w_abs_b   = (w_sgn && EXE_SrcB[31]) ? -EXE_SrcB : EXE_SrcB;
  assign w_quo_fix = r_neg_q ? -w_quo : w_quo;
  assign w_rem_fix = r_neg_r ? -w_rem : w_rem;

  divu_iter u_divu_iter (
    .clk       (clk),
    .resetn    (resetn),
    .load      (w_div_load),
    .step      (w_div_step),
    .dividend  (w_abs_a),
    .divisor   (w_abs_b),
    .quotient  (w_quo),
    .remainder (w_rem)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_res_load  = 1'b0;
    w_res_nxt   = {r_hi, r_lo};
    w_div_load  = 1'b0;
    w_div_step  = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_start) begin
          if (is_mul_op(w_op)) begin
            if (MUL_LATENCY == 1) begin
              w_state_nxt = StDone;
              w_res_load  = 1'b1;
              w_res_nxt   = w_mul_out;
            end else begin
              w_state_nxt = StMul;
              w_cnt_nxt   = MulCntInit;
            end
          end else if (EXE_SrcB == 32'd0) begin
            w_state_nxt = StDone;
            w_res_load  = 1'b1;
            w_res_nxt   = {EXE_SrcA, 32'hFFFF_FFFF};
          end else begin
            w_state_nxt = StDiv;
            w_cnt_nxt   = DivCntInit;
            w_div_load  = 1'b1;
          end
        end
      end
      StMul: begin
        if (Flush_Exception) begin
          w_state_nxt = StIdle;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CntOne) begin
          w_state_nxt = StDone;
          w_cnt_nxt   = '0;
          w_res_load  = 1'b1;
          w_res_nxt   = w_mul_out;
        end else begin
          w_cnt_nxt = r_cnt - CntOne;
        end
      end
      StDiv: begin
        if (Flush_Exception) begin
          w_state_nxt = StIdle;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CntOne) begin
          w_state_nxt = StDone;
          w_cnt_nxt   = '0;
          w_res_load  = 1'b1;
          w_res_nxt   = {w_rem_fix, w_quo_fix};
        end else begin
          w_cnt_nxt  = r_cnt - CntOne;
          w_div_step = 1'b1;
        end
      end
      StDone: begin
        if (Flush_Exception || !EXE_Stall) w_state_nxt = StIdle;
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= StIdle;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_hi    <= '0;
      r_lo    <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else begin
      if (w_res_load) {r_hi, r_lo} <= w_res_nxt;
      if (w_div_load) begin
        r_neg_q <= w_sgn & (EXE_SrcA[31] ^ EXE_SrcB[31]);
        r_neg_r <= w_sgn & EXE_SrcA[31];
      end
    end
  end

  assign DIVMULTBusy     = !Flush_Exception &&
                           (w_start || (r_state == StMul) || (r_state == StDiv));
  assign MulDiv_ResValid = (r_state == StDone);
  assign MulDiv_HI       = r_hi;
  assign MulDiv_LO       = r_lo;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboarded bench for muldiv_ctrl: directed corner ops, random ops, flush, stall and reset.
module tb_muldiv_ctrl;
  import muldiv_ctrl_pkg::*;

  localparam int MulLat  = 2;
  localparam int DivIter = 32;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        EXE_Valid = 1'b0;
  logic [3:0]  EXE_MulDivOp = 4'd0;
  logic [31:0] EXE_SrcA = '0, EXE_SrcB = '0, HI_In = '0, LO_In = '0;
  logic        EXE_Stall = 1'b0, Flush_Exception = 1'b0;
  logic        DIVMULTBusy, MulDiv_ResValid;
  logic [31:0] MulDiv_HI, MulDiv_LO;

  always #5 clk = ~clk;

  muldiv_ctrl #(
    .MUL_LATENCY (MulLat),
    .DIV_ITER    (DivIter)
  ) dut (
    .clk             (clk),
    .resetn          (resetn),
    .EXE_Valid       (EXE_Valid),
    .EXE_MulDivOp    (EXE_MulDivOp),
    .EXE_SrcA        (EXE_SrcA),
    .EXE_SrcB        (EXE_SrcB),
    .HI_In           (HI_In),
    .LO_In           (LO_In),
    .EXE_Stall       (EXE_Stall),
    .Flush_Exception (Flush_Exception),
    .DIVMULTBusy     (DIVMULTBusy),
    .MulDiv_ResValid (MulDiv_ResValid),
    .MulDiv_HI       (MulDiv_HI),
    .MulDiv_LO       (MulDiv_LO)
  );

  logic [63:0] sb_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Reference {HI,LO} computed with native SV arithmetic.
  function automatic logic [63:0] model(input muldiv_op_t op, input logic [31:0] a, b, hi, lo);
    longint      sa, sb;
    logic [63:0] sp, up, acc;
    int          ia, ib, q, r;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    sp  = 64'(sa * sb);
    up  = {32'h0, a} * {32'h0, b};
    acc = {hi, lo};
    ia  = int'(a);
    ib  = int'(b);
    case (op)
      OpMult:  return sp;
      OpMultu: return up;
      OpMadd:  return acc + sp;
      OpMaddu: return acc + up;
      OpMsub:  return acc - sp;
      OpMsubu: return acc - up;
      OpDiv: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        q = ia / ib;
        r = ia % ib;
        return {32'(r), 32'(q)};
      end
      OpDivu: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      default: return 64'h0;
    endcase
  endfunction

  always @(negedge clk) begin
    if (resetn && MulDiv_ResValid) begin
      if (sb_q.size() == 0) begin
        check_eq("spurious_valid", 64'(MulDiv_ResValid), 64'd0);
      end else begin
        check_eq("hilo", {MulDiv_HI, MulDiv_LO}, sb_q[0]);
        if (!EXE_Stall || Flush_Exception) void'(sb_q.pop_front());
      end
    end
  end

  task automatic run_op(input muldiv_op_t op, input logic [31:0] a, b, hi, lo,
                        input int exp_busy, input int stall_cyc);
    int n_busy  = 0;
    int n_valid = 0;
    int guard   = 0;
    @(posedge clk);
    #1;
    sb_q.push_back(model(op, a, b, hi, lo));
    EXE_Valid    = 1'b1;
    EXE_MulDivOp = op;
    EXE_SrcA     = a;
    EXE_SrcB     = b;
    HI_In        = hi;
    LO_In        = lo;
    EXE_Stall    = (stall_cyc > 0);
    forever begin
      @(negedge clk);
      if (DIVMULTBusy) n_busy++;
      if (MulDiv_ResValid) begin
        n_valid++;
        if (n_valid > stall_cyc) break;
      end
      guard++;
      if (guard > 200) begin
        check_eq("timeout", 64'(MulDiv_ResValid), 64'd1);
        break;
      end
      @(posedge clk);
      #1;
      EXE_Stall = (n_valid < stall_cyc);
    end
    @(posedge clk);
    #1;
    EXE_Valid    = 1'b0;
    EXE_MulDivOp = OpNone;
    EXE_Stall    = 1'b0;
    check_eq({"busy_", op.name()}, 64'(n_busy), 64'(exp_busy));
    check_eq("valid_cycles", 64'(n_valid), 64'(stall_cyc + 1));
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_busy", 64'(DIVMULTBusy), 64'd0);
    check_eq("rst_valid", 64'(MulDiv_ResValid), 64'd0);
    check_eq("rst_hilo", {MulDiv_HI, MulDiv_LO}, 64'd0);
    @(posedge clk);
    #1;
    resetn = 1'b1;

    run_op(OpMult,  32'hFFFF_FFFD, 32'd5,         32'h0, 32'h0, MulLat, 0);
    run_op(OpDiv,   32'd7,         32'hFFFF_FFFE, 32'h0, 32'h0, DivIter + 1, 0);
    run_op(OpDivu,  32'hFFFF_FFFF, 32'h10,        32'h0, 32'h0, DivIter + 1, 0);
    run_op(OpDivu,  32'h1234,      32'h0,         32'h0, 32'h0, 1, 0);
    run_op(OpDiv,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h0, DivIter + 1, 0);
    run_op(OpMaddu, 32'd1, 32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MulLat, 0);
    run_op(OpMsub,  32'd1, 32'd1, 32'h0, 32'h0, MulLat, 0);
    run_op(OpDiv,   32'hFFFF_FF9C, 32'd7, 32'h0, 32'h0, DivIter + 1, 0);

    for (int i = 0; i < 8; i++) begin
      muldiv_op_t  op;
      logic [31:0] a, b;
      int          eb;
      op = muldiv_op_t'($urandom_range(1, 8));
      a  = $urandom;
      b  = (i == 3) ? 32'h0 : ((i % 2 == 1) ? 32'($urandom_range(1, 300)) : $urandom);
      if (op == OpDiv || op == OpDivu) eb = (b == 32'h0) ? 1 : DivIter + 1;
      else eb = MulLat;
      run_op(op, a, b, $urandom, $urandom, eb, 0);
    end

    // Flush a divide in its 10th busy cycle.
    @(posedge clk);
    #1;
    EXE_Valid    = 1'b1;
    EXE_MulDivOp = OpDiv;
    EXE_SrcA     = 32'd100;
    EXE_SrcB     = 32'd7;
    repeat (8) @(posedge clk);
    @(negedge clk);
    check_eq("div_busy_pre_flush", 64'(DIVMULTBusy), 64'd1);
    @(posedge clk);
    #1;
    Flush_Exception = 1'b1;
    @(negedge clk);
    check_eq("flush_busy", 64'(DIVMULTBusy), 64'd0);
    check_eq("flush_valid", 64'(MulDiv_ResValid), 64'd0);
    @(posedge clk);
    #1;
    Flush_Exception = 1'b0;
    EXE_Valid       = 1'b0;
    EXE_MulDivOp    = OpNone;
    @(negedge clk);
    check_eq("post_flush_busy", 64'(DIVMULTBusy), 64'd0);
    check_eq("post_flush_valid", 64'(MulDiv_ResValid), 64'd0);
    run_op(OpMultu, 32'd2, 32'd3, 32'h0, 32'h0, MulLat, 0);

    // Result held through two stalled DONE cycles, retired on the third.
    run_op(OpMult, 32'h0001_2345, 32'hFFFF_0001, 32'h0, 32'h0, MulLat, 2);

    // Reset in the middle of a divide.
    @(posedge clk);
    #1;
    EXE_Valid    = 1'b1;
    EXE_MulDivOp = OpDiv;
    EXE_SrcA     = 32'd1000;
    EXE_SrcB     = 32'd3;
    repeat (5) @(posedge clk);
    #1;
    resetn       = 1'b0;
    EXE_Valid    = 1'b0;
    EXE_MulDivOp = OpNone;
    @(posedge clk);
    #1;
    resetn = 1'b1;
    @(negedge clk);
    check_eq("mid_rst_busy", 64'(DIVMULTBusy), 64'd0);
    check_eq("mid_rst_valid", 64'(MulDiv_ResValid), 64'd0);
    check_eq("mid_rst_hilo", {MulDiv_HI, MulDiv_LO}, 64'd0);
    run_op(OpDivu, 32'd1000, 32'd3, 32'h0, 32'h0, DivIter + 1, 0);

    repeat (3) @(negedge clk);
    check_eq("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
